router_mp_core: RTL

//  Parametrised store-and-forward packet router core; next generation of the single-port router DUT.

---
 rtl/router_mp_if.sv | 23 ++
 rtl/router_mp_core.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/router_mp_if.sv
// Packet router bus: byte-stream input, per-port outputs and status.
interface router_mp_if #(
  parameter int DW        = 8,
  parameter int NUM_PORTS = 4
);
  logic [DW-1:0]           dut_inp;
  logic                    inp_valid;
  logic [NUM_PORTS*DW-1:0] dut_outp;
  logic [NUM_PORTS-1:0]    outp_valid;
  logic                    busy;
  logic [3:0]              error;
  logic [15:0]             drop_count;

  modport master (
    output dut_inp, inp_valid,
    input  dut_outp, outp_valid, busy, error, drop_count
  );

  modport slave (
    input  dut_inp, inp_valid,
    output dut_outp, outp_valid, busy, error, drop_count
  );
endinterface

// File: rtl/router_mp_core.sv
// Store-and-forward packet router: buffers one whole packet, validates
// size, length field, destination and XOR checksum, then replays it on the
// selected output port. Rejected packets are reported on error and counted.
module router_mp_core #(
  parameter int DW        = 8,
  parameter int NUM_PORTS = 4,
  parameter int MIN_PKT   = 4,
  parameter int MAX_PKT   = 64
) (
  input  logic       clk,
  input  logic       reset,
  router_mp_if.slave bus
);
  localparam int AW = $clog2(MAX_PKT);
  localparam int CW = $clog2(MAX_PKT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK, S_SEND} state_t;

  state_t                  state, state_nxt;
  logic [DW-1:0]           pkt_buf [MAX_PKT];
  logic [CW-1:0]           cnt;
  logic                    ovf;
  logic [DW-1:0]           crc;
  logic [AW-1:0]           rd_ptr;
  logic                    viol;
  logic [3:0]              error_q;
  logic [15:0]             drop_q;

  logic                    busy_w;
  logic                    accept_w;
  logic                    viol_w;
  logic                    last_w;
  logic [3:0]              chk_code;
  logic [NUM_PORTS*DW-1:0] outp_w;
  logic [NUM_PORTS-1:0]    valid_w;

  assign busy_w = (state == S_CHECK) || (state == S_SEND);
  // A word is taken only while idle/receiving and not inside an ignored burst.
  assign accept_w = bus.inp_valid && !busy_w && !viol;
  assign viol_w   = bus.inp_valid && busy_w;
  // cnt equals the verified length once SEND is reached.
  assign last_w   = (CW'(rd_ptr) == (cnt - CW'(1)));

  // Packet validation, first failing check in priority order wins.
  always_comb begin
    chk_code = 4'd0;
    if (ovf)
      chk_code = 4'd4;
    else if (cnt < CW'(MIN_PKT))
      chk_code = 4'd3;
    else if (DW'(cnt) != pkt_buf[1])
      chk_code = 4'd5;
    else if (pkt_buf[0] >= DW'(NUM_PORTS))
      chk_code = 4'd6;
    else if (crc != '0)
      chk_code = 4'd2;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_w) state_nxt = S_RECV;
      S_RECV:  if (!bus.inp_valid) state_nxt = S_CHECK;
      S_CHECK: state_nxt = (chk_code == 4'd0) ? S_SEND : S_IDLE;
      S_SEND:  if (last_w) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, word count, running checksum, status and violation tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ovf     <= 1'b0;
      crc     <= '0;
      rd_ptr  <= '0;
      viol    <= 1'b0;
      error_q <= 4'd0;
      drop_q  <= 16'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (accept_w) begin
            cnt <= CW'(1);
            ovf <= 1'b0;
            crc <= bus.dut_inp;
          end
        end
        S_RECV: begin
          if (accept_w) begin
            if (cnt < CW'(MAX_PKT)) begin
              cnt <= cnt + CW'(1);
              crc <= crc ^ bus.dut_inp;
            end else begin
              ovf <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          error_q <= chk_code;
          rd_ptr  <= '0;
          if ((chk_code != 4'd0) && (drop_q != 16'hFFFF))
            drop_q <= drop_q + 16'd1;
        end
        S_SEND: begin
          rd_ptr <= last_w ? '0 : rd_ptr + AW'(1);
        end
        default: ;
      endcase
      // A burst that collides with a busy router is ignored to its end,
      // and only released once the line is quiet and the router idle.
      if (viol_w) begin
        viol    <= 1'b1;
        error_q <= 4'd1;
      end else if (!bus.inp_valid && !busy_w) begin
        viol <= 1'b0;
      end
    end
  end

  // Packet storage; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept_w) begin
      if (state == S_IDLE)
        pkt_buf[0] <= bus.dut_inp;
      else if ((state == S_RECV) && (cnt < CW'(MAX_PKT)))
        pkt_buf[cnt[AW-1:0]] <= bus.dut_inp;
    end
  end

  // Output steering: only the destination port carries data during SEND.
  always_comb begin
    outp_w  = '0;
    valid_w = '0;
    if (state == S_SEND) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (pkt_buf[0] == DW'(p)) begin
          valid_w[p]          = 1'b1;
          outp_w[p*DW +: DW]  = pkt_buf[rd_ptr];
        end
      end
    end
  end

  assign bus.dut_outp   = outp_w;
  assign bus.outp_valid = valid_w;
  assign bus.busy       = busy_w;
  assign bus.error      = error_q;
  assign bus.drop_count = drop_q;
endmodule
